ifetch_sram_bridge: RTL and testbench
=====================================

Name: ifetch_sram_bridge

Overview:
- Slave end of the instruction-fetch handshake: accepts PC requests from the fetch unit and returns 32-bit instruction words read from a synchronous single-port instruction SRAM.
- Supports up to DEPTH outstanding requests, so a pipelined fetcher sustains one instruction per cycle.
- Misaligned or out-of-window PCs return a fault response in order, without touching the SRAM.

Parameters:
- PC_W, 32, request PC width (equals RV_PC_SIZE).
- IR_W, 32, instruction width (equals RV_IR_SIZE).
- MEM_AW, 12, SRAM word-address width (4096 words = 16 KiB window).
- BASE_ADDR, 32'h0000_0000, byte address mapped to SRAM word 0; must be 4-byte aligned.
- DEPTH, 2, response buffer entries and the maximum number of outstanding requests; must be ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ifetch_req_vld  in  1  request valid.
- ifetch_req_rdy  out  1  request ready.
- ifetch_req_pc  in  PC_W  byte PC to fetch.
- ifetch_rsp_vld  out  1  response valid.
- ifetch_rsp_rdy  in  1  response ready.
- ifetch_rsp_ir  out  IR_W  fetched instruction.
- ifetch_rsp_err  out  1  fetch fault for this response.
- mem_cs  out  1  SRAM read strobe.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_rdata  in  IR_W  SRAM data; valid exactly one cycle after mem_cs.
- err_cnt  out  8  saturating count of faulted requests.

Behaviour:
- Handshakes:
  - req_hsk = req_vld & req_rdy; rsp_hsk = rsp_vld & rsp_rdy.
  - Payload must be stable while vld is high and rdy is low.
- Fault check, per request:
  - off = req_pc - BASE_ADDR, computed modulo 2^PC_W.
  - fault = (req_pc[1:0] != 0) | (off >= 4 << MEM_AW).
  - Not faulted: mem_cs = 1, mem_addr = off[MEM_AW+1:2].
  - Faulted: mem_cs = 0.
- mem_cs = req_hsk & ~fault, combinational. mem_addr is don't-care when mem_cs = 0.
- Stage 1 register (s1_vld, s1_err) captures req_hsk and fault on every clock edge.
- Response buffer write, in the cycle after req_hsk:
  - s1_vld writes entry {ir = s1_err ? FAULT_IR : mem_rdata, err = s1_err} into the response FIFO.
- Latency: request accepted in cycle t, rsp_vld asserted in cycle t+2 at the earliest.
- Responses return strictly in request order.
- Credit: occ = FIFO count + s1_vld.
  - req_rdy = (occ < DEPTH) | (rsp_hsk & occ == DEPTH).
  - This guarantees no FIFO overflow, so no write is ever dropped.
- Throughput:
  - With DEPTH = 2 and rsp_rdy held at 1, back-to-back requests are accepted every cycle.
  - If rsp_rdy is held at 0, at most DEPTH requests are accepted, then req_rdy = 0.
- Response outputs: rsp_vld = FIFO not empty; rsp_ir and rsp_err come from the FIFO head. rsp_hsk pops the head.
- Simultaneous FIFO push and pop: count is unchanged, and the push lands behind the head.
- Push into an empty FIFO: the data becomes visible the next cycle; there is no combinational bypass.
- err_cnt:
  - Increments on req_hsk & fault.
  - Saturates at 8'hFF.
  - Never wraps.
- Reset values:
  - req_rdy = 1 immediately after reset (occ = 0).
  - rsp_vld = 0, rsp_ir = 0, rsp_err = 0, mem_cs = 0, err_cnt = 0.
  - s1_vld = 0; FIFO pointers and count = 0.
- Reset mid-operation: all in-flight and buffered responses are discarded. mem_rdata arriving after reset is ignored because s1_vld = 0.

Decomposition:
- Package ifetch_pkg:
  - FAULT_IR = 32'h0000_0000 (architecturally illegal encoding).
  - Typedef ifetch_rsp_t {logic [IR_W-1:0] ir; logic err;}.
  - Word-offset helper function.
- Sub-module ifetch_rsp_fifo:
  - Parameterised synchronous FIFO of ifetch_rsp_t with DEPTH entries.
  - Ports: push, push data, pop, head data, count, empty, full.
  - Asynchronous reset.

Test Plan:
- Single fetch: SRAM word 3 = 32'h0010_0093; req_pc = 32'h0000_000C at t -> mem_cs = 1 and mem_addr = 3 at t; rsp_vld at t+2 with ir = 32'h0010_0093, err = 0.
- Streaming: rsp_rdy = 1; PCs 0, 4, 8, 12 on consecutive cycles -> req_rdy stays 1; four responses on consecutive cycles, in order, with the matching SRAM words.
- Backpressure: rsp_rdy = 0; offer PCs 0, 4, 8 -> only two accepted, req_rdy = 0 from the third cycle. Raise rsp_rdy -> words for 0 and 4 drain in order, then PC 8 is accepted.
- Faults:
  - req_pc = 32'h0000_0002 -> no mem_cs; rsp ir = 0, err = 1; err_cnt = 1.
  - req_pc = 32'h0000_4000 with MEM_AW = 12 -> same fault response; err_cnt = 2.
  - A valid fetch interleaved between the faults keeps its order and returns err = 0.
- Saturation: 300 faulted requests -> err_cnt = 8'hFF and holds at 8'hFF.
- Reset mid-flight: assert rst_n = 0 one cycle after req_hsk -> rsp_vld = 0, err_cnt = 0, req_rdy = 1 during reset; no stale response appears after release.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction-fetch SRAM bridge.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package ifetch_pkg;

    localparam int RV_PC_SIZE = 32;
    localparam int RV_IR_SIZE = 32;

    // All-zero word is an illegal RISC-V encoding, so a faulted fetch can never
    // be mistaken for a real instruction even if err is ignored downstream.
    localparam logic [RV_IR_SIZE-1:0] FAULT_IR = 32'h0000_0000;

    typedef struct packed {
        logic [RV_IR_SIZE-1:0] ir;
        logic                  err;
    } ifetch_rsp_t;

    // Byte offset of a PC from the SRAM window base, modulo 2^PC width.
    // Bits [1:0] give the misalignment, bits [MEM_AW+1:2] the word address,
    // and anything above that set means the PC is outside the window.
    function automatic logic [RV_PC_SIZE-1:0] pc_word_off(
        input logic [RV_PC_SIZE-1:0] pc,
        input logic [RV_PC_SIZE-1:0] base
    );
        return pc - base;
    endfunction

endpackage

// File: rtl/ifetch_rsp_fifo.sv
// In-order response buffer holding fetched instructions and fault flags.
// Latency: a push becomes visible at the head the cycle after it is written.
// Backpressure: caller must not push when full unless also popping.
module ifetch_rsp_fifo
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  ifetch_rsp_t        push_dat,
    input  logic               pop,
    output ifetch_rsp_t        head_dat,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full
);

    ifetch_rsp_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_pop;

    // Pointers wrap at DEPTH so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop   = pop & ~empty;
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign head_dat = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_sram_bridge.sv
// Fetch-side slave that turns PC requests into synchronous SRAM reads, faulting bad PCs.
// Latency: request accepted in cycle t gives a response at t+2 at the earliest.
// Backpressure: credit-based; req_rdy drops once DEPTH responses are owed, no drops.
module ifetch_sram_bridge
    import ifetch_pkg::*;
#(
    parameter int          PC_W      = 32,
    parameter int          IR_W      = 32,
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifetch_req_vld,
    output logic              ifetch_req_rdy,
    input  logic [PC_W-1:0]   ifetch_req_pc,
    output logic              ifetch_rsp_vld,
    input  logic              ifetch_rsp_rdy,
    output logic [IR_W-1:0]   ifetch_rsp_ir,
    output logic              ifetch_rsp_err,
    output logic              mem_cs,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [IR_W-1:0]   mem_rdata,
    output logic [7:0]        err_cnt
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [RV_PC_SIZE-1:0] off;
    logic                  misalign;
    logic                  out_of_window;
    logic                  fault;
    logic                  req_hsk;
    logic                  rsp_hsk;

    logic                  s1_vld;
    logic                  s1_err;

    ifetch_rsp_t           fifo_wdat;
    ifetch_rsp_t           fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_push;
    logic [OCC_W-1:0]      occ;

    // BASE_ADDR is word aligned, so the offset's low bits are the PC's low bits.
    assign off           = pc_word_off(RV_PC_SIZE'(ifetch_req_pc), RV_PC_SIZE'(BASE_ADDR));
    assign misalign      = |off[1:0];
    assign out_of_window = |off[RV_PC_SIZE-1:MEM_AW+2];
    assign fault         = misalign | out_of_window;

    assign req_hsk = ifetch_req_vld & ifetch_req_rdy;
    assign rsp_hsk = ifetch_rsp_vld & ifetch_rsp_rdy;

    // Faulted PCs never reach the SRAM; address is only meaningful with mem_cs.
    assign mem_cs   = req_hsk & ~fault;
    assign mem_addr = off[MEM_AW+1:2];

    // Every accepted request, fetched or faulted, owes one response slot. Counting
    // the read still in flight in stage 1 means the FIFO can never overflow.
    assign occ            = OCC_W'(fifo_count) + OCC_W'(s1_vld);
    assign ifetch_req_rdy = (occ < OCC_W'(DEPTH)) |
                            (rsp_hsk & (occ == OCC_W'(DEPTH)));

    // Stage 1 tracks the read whose data arrives on mem_rdata next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_err <= 1'b0;
        end else begin
            s1_vld <= req_hsk;
            s1_err <= fault;
        end
    end

    // Faulted slots carry the illegal encoding instead of whatever is on the bus.
    always_comb begin
        fifo_wdat     = '0;
        fifo_wdat.err = s1_err;
        fifo_wdat.ir  = s1_err ? FAULT_IR : RV_IR_SIZE'(mem_rdata);
    end

    // The credit scheme guarantees room; the full term only matters if that is violated.
    assign fifo_push = s1_vld & (~fifo_full | rsp_hsk);

    ifetch_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (fifo_wdat),
        .pop      (rsp_hsk),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign ifetch_rsp_vld = ~fifo_empty;
    assign ifetch_rsp_ir  = IR_W'(fifo_head.ir);
    assign ifetch_rsp_err = fifo_head.err;

    // Saturating fault counter, sticks at 0xFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (req_hsk && fault && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ifetch_sram_bridge.sv
// Self-checking bench for ifetch_sram_bridge against a queue-based response model.
// Latency: model expects each response two cycles after its request is accepted.
// Backpressure: random rsp_rdy stalls; requests held stable until accepted.
module tb_ifetch_sram_bridge;

    localparam int          MEM_AW = 12;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ifetch_req_vld;
    logic              ifetch_req_rdy;
    logic [31:0]       ifetch_req_pc;
    logic              ifetch_rsp_vld;
    logic              ifetch_rsp_rdy;
    logic [31:0]       ifetch_rsp_ir;
    logic              ifetch_rsp_err;
    logic              mem_cs;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [7:0]        err_cnt;

    ifetch_sram_bridge #(
        .PC_W      (32),
        .IR_W      (32),
        .MEM_AW    (MEM_AW),
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifetch_req_vld (ifetch_req_vld),
        .ifetch_req_rdy (ifetch_req_rdy),
        .ifetch_req_pc  (ifetch_req_pc),
        .ifetch_rsp_vld (ifetch_rsp_vld),
        .ifetch_rsp_rdy (ifetch_rsp_rdy),
        .ifetch_rsp_ir  (ifetch_rsp_ir),
        .ifetch_rsp_err (ifetch_rsp_err),
        .mem_cs         (mem_cs),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: data one cycle after the strobe, garbage otherwise.
    logic [31:0] sram [0:(1<<MEM_AW)-1];
    always @(posedge clk) begin
        mem_rdata <= mem_cs ? sram[mem_addr] : $urandom;
    end

    typedef struct {
        logic [31:0] ir;
        logic        err;
        int          avail;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   m_errs  = 0;
    int   checks  = 0;
    int   errors  = 0;
    logic acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic logic is_fault(input logic [31:0] pc);
        logic [31:0] o;
        o = pc - BASE;
        return (pc[1:0] != 2'b00) || (o >= (32'd4 << MEM_AW));
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        logic [31:0] o;
        o = (pc - BASE) >> 2;
        return sram[o[MEM_AW-1:0]];
    endfunction

    // One cycle: drive inputs after the falling edge, compare everything against the model.
    task automatic step(input logic vld, input logic [31:0] pc, input logic rrdy, output logic accepted);
        logic m_rsp_vld;
        logic m_rdy;
        logic m_f;
        logic [31:0] waddr;
        exp_t e;
        @(negedge clk);
        ifetch_req_vld = vld;
        ifetch_req_pc  = pc;
        ifetch_rsp_rdy = rrdy;
        #1;
        m_rsp_vld = (q.size() > 0) && (q[0].avail <= cyc);
        m_rdy     = (q.size() < DEPTH) || ((q.size() == DEPTH) && m_rsp_vld && rrdy);
        m_f       = is_fault(pc);
        chk("req_rdy", ifetch_req_rdy, m_rdy);
        chk("rsp_vld", ifetch_rsp_vld, m_rsp_vld);
        if (m_rsp_vld) begin
            chk("rsp_ir", ifetch_rsp_ir, q[0].ir);
            chk("rsp_err", ifetch_rsp_err, q[0].err);
        end
        chk("mem_cs", mem_cs, vld && m_rdy && !m_f);
        if (vld && m_rdy && !m_f) begin
            waddr = (pc - BASE) >> 2;
            chk("mem_addr", mem_addr, waddr);
        end
        chk("err_cnt", err_cnt, (m_errs > 255) ? 255 : m_errs);
        if (m_rsp_vld && rrdy) void'(q.pop_front());
        accepted = vld && m_rdy;
        if (accepted) begin
            e.ir    = m_f ? 32'h0 : word_of(pc);
            e.err   = m_f;
            e.avail = cyc + 2;
            q.push_back(e);
            if (m_f) m_errs++;
        end
        cyc++;
    endtask

    task automatic offer(input logic [31:0] pc, input logic rrdy);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 40 && !a; i++) step(1'b1, pc, rrdy, a);
        if (!a) timeout("offer");
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 50 && q.size() > 0; i++) step(1'b0, $urandom, 1'b1, a);
        if (q.size() > 0) timeout("drain");
    endtask

    function automatic logic [31:0] rand_pc();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)       return BASE + {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
        else if (r < 8)  return BASE + {18'd0, 12'($urandom_range(0, 4095)), 2'($urandom_range(1, 3))};
        else if (r == 8) return BASE + 32'h4000 + {$urandom_range(0, 1000), 2'b00};
        else             return ($urandom_range(0, 1) == 1) ? BASE + 32'h3FFC : 32'hFFFF_FFFC;
    endfunction

    initial begin
        logic        pend;
        logic [31:0] ppc;
        for (int i = 0; i < (1 << MEM_AW); i++) sram[i] = $urandom;
        sram[3]        = 32'h0010_0093;
        rst_n          = 1'b0;
        ifetch_req_vld = 1'b0;
        ifetch_req_pc  = '0;
        ifetch_rsp_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_rdy", ifetch_req_rdy, 1);
        chk("rst_rsp_vld", ifetch_rsp_vld, 0);
        chk("rst_rsp_ir", ifetch_rsp_ir, 0);
        chk("rst_rsp_err", ifetch_rsp_err, 0);
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single fetch with hand-computed expectations.
        step(1'b1, 32'h0000_000C, 1'b1, acc);
        chk("single_cs", mem_cs, 1);
        chk("single_addr", mem_addr, 3);
        step(1'b0, 32'h0, 1'b1, acc);
        chk("single_t1_vld", ifetch_rsp_vld, 0);
        step(1'b0, 32'h0, 1'b1, acc);
        chk("single_t2_vld", ifetch_rsp_vld, 1);
        chk("single_ir", ifetch_rsp_ir, 32'h0010_0093);
        chk("single_err", ifetch_rsp_err, 0);
        drain();

        // Streaming: four back-to-back fetches must all be accepted.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'(4 * i), 1'b1, acc);
            chk("stream_acc", acc, 1);
        end
        drain();

        // Backpressure: only DEPTH accepted while the consumer stalls.
        offer(32'h0, 1'b0);
        offer(32'h4, 1'b0);
        step(1'b1, 32'h8, 1'b0, acc);
        chk("bp_rdy_low", ifetch_req_rdy, 0);
        step(1'b1, 32'h8, 1'b0, acc);
        chk("bp_still_low", acc, 0);
        offer(32'h8, 1'b1);
        drain();

        // Faults interleaved with a good fetch.
        step(1'b1, 32'h0000_0002, 1'b1, acc);
        chk("fault_mis_cs", mem_cs, 0);
        step(1'b1, 32'h0000_0008, 1'b1, acc);
        step(1'b1, 32'h0000_4000, 1'b1, acc);
        chk("fault_oow_cs", mem_cs, 0);
        chk("fault_rsp_err", ifetch_rsp_err, 1);
        chk("fault_rsp_ir", ifetch_rsp_ir, 0);
        drain();
        chk("fault_cnt2", err_cnt, 2);

        // Saturation of the fault counter.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 32'h0000_4000 + 32'(i * 4), 1'b1, acc);
            chk("sat_acc", acc, 1);
        end
        drain();
        chk("sat_ff", err_cnt, 8'hFF);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h1, 1'b1, acc);
        drain();
        chk("sat_hold", err_cnt, 8'hFF);

        // Randomised traffic with random consumer stalls.
        pend = 1'b0;
        ppc  = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend = 1'b1;
                ppc  = rand_pc();
            end
            step(pend, pend ? ppc : $urandom, ($urandom_range(0, 2) != 0), acc);
            if (acc) pend = 1'b0;
        end
        drain();

        // Reset in the middle of traffic discards everything in flight.
        step(1'b1, 32'h0000_0001, 1'b1, acc);
        step(1'b1, 32'h0000_0010, 1'b1, acc);
        @(negedge clk);
        rst_n          = 1'b0;
        ifetch_req_vld = 1'b0;
        #1;
        chk("mid_rst_rsp_vld", ifetch_rsp_vld, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_req_rdy", ifetch_req_rdy, 1);
        q.delete();
        m_errs = 0;
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, acc);
        chk("post_rst_err_cnt", err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
